fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on input and output. It supersedes the single-format `fp_13` datapath with configurable exponent/mantissa widths, round-to-nearest-even, special-value handling and backpressure. It sits between operand-issue logic and the result writeback. It accepts one operation per cycle and returns results in order after a fixed 3-cycle latency when not stalled.

## Interface
- `EXP_W`, default 8: exponent field width, minimum 3.
- `MAN_W`, default 23: stored mantissa (fraction) width, minimum 4.
- `W` (localparam) = 1+EXP_W+MAN_W: operand/result width, `{sign, exp, frac}`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: unit accepts operands this cycle.
- `op` input 1: 0 = a+b, 1 = a−b.
- `a`, `b` input W: operands.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `c` output W: result.
- `flags` output 4 (only with `FP_ADDSUB_FLAGS_EN`): {invalid, overflow, underflow, inexact}.

## Operation
- Transfer on input when `in_valid && in_ready`; on output when `out_valid && out_ready`.
- Effective b sign = b_s XOR op.
- Stage 1 (unpack/align):
  - Classify zero (exp=0, subnormals flushed to zero), inf, NaN (exp all-ones).
  - Swap so that |x| ≥ |y|; result sign defaults to x's sign.
  - Right-shift y's significand (hidden 1 prepended) by the exponent difference, keeping guard, round and sticky bits; a shift ≥ MAN_W+3 leaves only sticky.
- Stage 2 (add): add or subtract significands on MAN_W+4 bits plus carry; record the leading-zero count.
- Stage 3 (normalise/round):
  - Shift left by the leading-zero count or right by 1 on carry; adjust the exponent.
  - Round to nearest, ties to even; handle a rounding carry-out by renormalising.
- Results:
  - Exact zero sum of opposite-sign operands → +0. (−0)+(−0) → −0.
  - Exponent ≥ all-ones after rounding → ±inf.
  - Exponent ≤ 0 → ±0 (FTZ, underflow).
  - Any NaN input, or inf − inf → canonical quiet NaN: sign 0, exp all-ones, frac MSB 1, rest 0.
  - inf ± finite → that inf.

## Timing
- Reset: `in_ready`=1; `out_valid`=0; `c`=0; `flags`=0; all stage valid bits cleared.
- Latency: exactly 3 cycles from input transfer to `out_valid` with `out_ready` held high. Throughput: 1 per cycle.
- Pipeline stall:
  - Stage k advances when its successor is empty or advancing.
  - `in_ready` = !v1 || stage 1 advancing, where v1 is stage 1's valid bit. This is combinational from `out_ready` through the stage valids.
  - No bubbles are inserted while `out_ready` is high.
- `c`/`flags` are held stable while `out_valid && !out_ready`.
- Registers in stages without a valid bit may take any value; outputs are only meaningful when `out_valid`=1.
- Simultaneous accept on input and output with a full pipeline: both transfers occur in the same cycle and no data is lost.
- `rst` asserted mid-operation: all in-flight results are dropped immediately (asynchronous). The first operation accepted after release returns 3 cycles later.
- Results are always returned in order.

## Configuration
- `FP_ADDSUB_FLAGS_EN` defined: `flags` port present; flags are computed in stages 1/3 and carried alongside `c` under the same handshake.
  - invalid: NaN input or inf−inf.
  - overflow: result became inf from finite inputs.
  - underflow: nonzero result flushed to zero.
  - inexact: nonzero guard/round/sticky bits, overflow, or underflow.
- Undefined: no `flags` port and no flag logic; the `c` datapath is identical.

## Test plan
Default parameters (EXP_W=8, MAN_W=23) for all scenarios.
- Basic add/sub: 3F800000+3F800000, op=0 → 40000000. Same operands, op=1 → 00000000. 3F800000 + BF800000, op=0 → 00000000. BF800000 − 3F800000 → C0000000.
- Rounding:
  - 3F800000 + 33800000 (exact tie) → 3F800000, inexact=1.
  - 3F800000 + 33800001 → 3F800001.
  - 3F800001 + 33800000 → 3F800002 (tie to even).
- Specials:
  - 7F800000 + FF800000 → 7FC00000, invalid=1.
  - 7F7FFFFF + 7F7FFFFF → 7F800000, overflow=1, inexact=1.
  - 00400000 (subnormal) + 00000000 → 00000000.
  - 7FC00001 + 3F800000 → 7FC00000.
- Streaming and backpressure:
  - 20 back-to-back random operations, `out_ready`=1: results match the reference model, one per cycle after a 3-cycle fill.
  - Repeat with `out_ready` toggled pseudo-randomly: `in_ready` drops when the pipeline is full, no results are lost or duplicated, and `c` is stable while stalled.
- Reset mid-stream: assert `rst` with 3 operations in flight → `out_valid`=0 immediately. After release, 40400000+3F800000 returns 40800000 exactly 3 cycles after acceptance, with no stale outputs.
- Alternate width: EXP_W=5, MAN_W=10. 3C00+3C00 → 4000. 7BFF+7BFF → 7C00.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined floating-point adder/subtractor with
// valid/ready handshakes on both sides, round-to-nearest-even, subnormals
// flushed to zero and canonical quiet-NaN generation.
//
// Parameters: EXP_W (exponent width, >= 3), MAN_W (stored fraction width, >= 4).
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; op selects a+b (0) or a-b (1)
//   a, b                operands {sign, exp, frac}
//   out_valid/out_ready result handshake
//   c                   result
//   flags               {invalid, overflow, underflow, inexact}, only when the
//                       FP_ADDSUB_FLAGS_EN macro is defined
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c
`ifdef FP_ADDSUB_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);
    // Significand layout: {hidden, fraction, guard, round, sticky}.
    localparam int unsigned SIG_W = MAN_W + 4;
    localparam int unsigned LZ_W  = $clog2(SIG_W + 1);
    // Signed exponent width, wide enough for exp + 2 and exp - SIG_W.
    localparam int unsigned EW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EW-1:0] EXP_MAX = {{(EW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

    // Handshake: a stage loads when it is empty or its contents move on.
    logic v1, v2, v3;
    logic en1, en2, en3;
    assign en3       = !v3 || out_ready;
    assign en2       = !v2 || en3;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    // ---------------- Stage 1: unpack, classify, swap, align ----------------
    logic             a_s, b_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_f, b_f;
    logic [W-2:0]     a_mag, b_mag;
    assign a_s    = a[W-1];
    assign b_s    = b[W-1] ^ op;
    assign a_e    = a[W-2:MAN_W];
    assign b_e    = b[W-2:MAN_W];
    assign a_f    = a[MAN_W-1:0];
    assign b_f    = b[MAN_W-1:0];
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_inf  = (&a_e) && !(|a_f);
    assign b_inf  = (&b_e) && !(|b_f);
    assign a_nan  = (&a_e) && (|a_f);
    assign b_nan  = (&b_e) && (|b_f);
    assign a_mag  = a_zero ? '0 : a[W-2:0];
    assign b_mag  = b_zero ? '0 : b[W-2:0];
    assign swap   = (b_mag > a_mag);

    logic             x_s, x_zero, y_zero, sticky, spec_d, inv_d;
    logic [EXP_W-1:0] x_e, y_e, d;
    logic [MAN_W-1:0] x_f, y_f;
    logic [SIG_W-1:0] xm_d, ym_d, y_sig;
    logic [W-1:0]     spec_val_d;

    always_comb begin
        x_s    = swap ? b_s : a_s;
        x_e    = swap ? b_e : a_e;
        x_f    = swap ? b_f : a_f;
        x_zero = swap ? b_zero : a_zero;
        y_e    = swap ? a_e : b_e;
        y_f    = swap ? a_f : b_f;
        y_zero = swap ? a_zero : b_zero;
        d      = x_e - y_e;
        y_sig  = {1'b1, y_f, 3'b000};
        sticky = 1'b0;
        ym_d   = '0;
        if (y_zero) begin
            ym_d = '0;
        end else if (32'(d) >= SIG_W - 1) begin
            ym_d = {{(SIG_W-1){1'b0}}, 1'b1};
        end else begin
            sticky = |(y_sig & ~({SIG_W{1'b1}} << d));
            ym_d   = (y_sig >> d) | {{(SIG_W-1){1'b0}}, sticky};
        end
        xm_d       = x_zero ? '0 : {1'b1, x_f, 3'b000};
        spec_d     = a_nan || b_nan || a_inf || b_inf;
        inv_d      = a_nan || b_nan || (a_inf && b_inf && (a_s ^ b_s));
        // With any infinity present and no NaN, x is an infinity.
        spec_val_d = inv_d ? QNAN : {x_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    logic             s1_sign, s1_sub, s1_spec;
    logic [EXP_W-1:0] s1_exp;
    logic [SIG_W-1:0] s1_xm, s1_ym;
    logic [W-1:0]     s1_spec_val;
`ifdef FP_ADDSUB_FLAGS_EN
    logic             s1_inv, s2_inv;
    logic [3:0]       flags_d, flags_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_spec <= 1'b0;
            s1_exp <= '0; s1_xm <= '0; s1_ym <= '0; s1_spec_val <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
            s1_inv <= 1'b0;
`endif
        end else if (en1) begin
            v1 <= in_valid; s1_sign <= x_s; s1_sub <= a_s ^ b_s; s1_spec <= spec_d;
            s1_exp <= x_e; s1_xm <= xm_d; s1_ym <= ym_d; s1_spec_val <= spec_val_d;
`ifdef FP_ADDSUB_FLAGS_EN
            s1_inv <= inv_d;
`endif
        end
    end

    // ---------------- Stage 2: add/subtract, leading-zero count -------------
    logic [SIG_W:0]  sum_d;
    logic [LZ_W-1:0] lzc_d;
    always_comb begin
        // |x| >= |y| so the difference never goes negative.
        sum_d = s1_sub ? ({1'b0, s1_xm} - {1'b0, s1_ym}) : ({1'b0, s1_xm} + {1'b0, s1_ym});
        lzc_d = LZ_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (sum_d[i]) lzc_d = LZ_W'(SIG_W - 1 - i);
        end
    end

    logic             s2_sign, s2_sub, s2_spec;
    logic [EXP_W-1:0] s2_exp;
    logic [SIG_W:0]   s2_sum;
    logic [LZ_W-1:0]  s2_lzc;
    logic [W-1:0]     s2_spec_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0; s2_sign <= 1'b0; s2_sub <= 1'b0; s2_spec <= 1'b0;
            s2_exp <= '0; s2_sum <= '0; s2_lzc <= '0; s2_spec_val <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
            s2_inv <= 1'b0;
`endif
        end else if (en2) begin
            v2 <= v1; s2_sign <= s1_sign; s2_sub <= s1_sub; s2_spec <= s1_spec;
            s2_exp <= s1_exp; s2_sum <= sum_d; s2_lzc <= lzc_d; s2_spec_val <= s1_spec_val;
`ifdef FP_ADDSUB_FLAGS_EN
            s2_inv <= s1_inv;
`endif
        end
    end

    // ---------------- Stage 3: normalise, round, pack -----------------------
    logic [SIG_W-1:0] norm;
    logic [EW-1:0]    e_base, e_norm, e_fin;
    logic [MAN_W+1:0] mant;
    logic [MAN_W-1:0] frac;
    logic             rnd_g, rnd_rs, rnd_up, ovf, unf, zero_sum;
    logic [W-1:0]     c_d, c_q;

    always_comb begin
        e_base = {{(EW-EXP_W){1'b0}}, s2_exp};
        if (s2_sum[SIG_W]) begin
            // Carry out: shift right one, folding the lost bit into sticky.
            norm   = s2_sum[SIG_W:1] | {{(SIG_W-1){1'b0}}, s2_sum[0]};
            e_norm = e_base + EW'(1);
        end else begin
            norm   = s2_sum[SIG_W-1:0] << s2_lzc;
            e_norm = e_base - {{(EW-LZ_W){1'b0}}, s2_lzc};
        end
        rnd_g    = norm[2];
        rnd_rs   = |norm[1:0];
        rnd_up   = rnd_g && (rnd_rs || norm[3]);
        mant     = {1'b0, norm[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        // Rounding carry-out leaves 10...0: renormalise by one.
        e_fin    = mant[MAN_W+1] ? e_norm + EW'(1) : e_norm;
        frac     = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
        ovf      = !e_fin[EW-1] && (e_fin >= EXP_MAX);
        unf      = e_fin[EW-1] || (e_fin == '0);
        zero_sum = (s2_sum == '0);

        if (s2_spec) begin
            c_d = s2_spec_val;
        end else if (zero_sum) begin
            // Cancellation gives +0; only same-sign zeros keep their sign.
            c_d = {s2_sign && !s2_sub, {(W-1){1'b0}}};
        end else if (ovf) begin
            c_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            c_d = {s2_sign, {(W-1){1'b0}}};
        end else begin
            c_d = {s2_sign, e_fin[EXP_W-1:0], frac};
        end

`ifdef FP_ADDSUB_FLAGS_EN
        flags_d = 4'b0000;
        if (s2_spec) begin
            flags_d = {s2_inv, 3'b000};
        end else if (!zero_sum) begin
            if (ovf)      flags_d = 4'b0101;
            else if (unf) flags_d = 4'b0011;
            else          flags_d = {3'b000, rnd_g || rnd_rs};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3  <= 1'b0;
            c_q <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
            flags_q <= '0;
`endif
        end else if (en3) begin
            v3  <= v2;
            c_q <= c_d;
`ifdef FP_ADDSUB_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign c = c_q;
`ifdef FP_ADDSUB_FLAGS_EN
    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: the driver pushes hand-computed
// expectations on each input transfer; an independent monitor pops and
// compares on each output transfer. A second EXP_W=5/MAN_W=10 instance covers
// the alternate format.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, c;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]  flags, flags16;
`endif

    logic        in_valid16, in_ready16, op16, out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] a16, b16, c16;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c)
`ifdef FP_ADDSUB_FLAGS_EN
        , .flags(flags)
`endif
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .c(c16)
`ifdef FP_ADDSUB_FLAGS_EN
        , .flags(flags16)
`endif
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] c;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  fl;
        logic        lchk;
        int          acc;
        int          id;
    } exp_t;

    vec_t        vq[$];
    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: never
    logic        held = 1'b0;
    logic [31:0] held_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic add_vec(input logic [31:0] xa, input logic [31:0] xb, input logic xo,
                           input logic [31:0] xc, input logic [3:0] xf);
        vec_t t;
        t.a = xa; t.b = xb; t.op = xo; t.c = xc; t.fl = xf;
        vq.push_back(t);
    endtask

    // Present one operation and hold it until accepted; returns stall cycles.
    task automatic issue(input vec_t v, input logic lchk, input int id, output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; a = v.a; b = v.b; op = v.op;
        #1;
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                n_bad++;
                $display("FAIL issue_timeout: in_ready stuck at 0 for op %0d, required 1", id);
                $fatal(1);
            end
            @(negedge clk);
            #1;
        end
        e.c = v.c; e.fl = v.fl; e.lchk = lchk; e.acc = cyc; e.id = id;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run16(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic o, input logic [15:0] want);
        int n = 0;
        @(negedge clk);
        in_valid16 = 1'b1; a16 = x; b16 = y; op16 = o;
        @(negedge clk);
        in_valid16 = 1'b0;
        while (!out_valid16 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 32'(out_valid16), 32'd1);
        chk(name, 32'(c16), 32'(want));
    endtask

    // Output ready pattern, updated on the falling edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare on every output transfer, check hold while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (held) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_c", c, held_c);
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got c=%h, required no output", c);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("result_%0d", e.id), c, e.c);
`ifdef FP_ADDSUB_FLAGS_EN
                        chk($sformatf("flags_%0d", e.id), {28'd0, flags}, {28'd0, e.fl});
`endif
                        if (e.lchk) chk($sformatf("latency_%0d", e.id), 32'(cyc - e.acc), 32'd3);
                    end
                end else begin
                    held   = 1'b1;
                    held_c = c;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int   w;
        vec_t rv;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; op16 = 1'b0;

        //       a             b             op    c             flags
        add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        add_vec(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000);
        add_vec(32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 4'b0000);
        add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        add_vec(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
        add_vec(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        add_vec(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        add_vec(32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
        add_vec(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        add_vec(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000);
        add_vec(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);
        add_vec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        add_vec(32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000);
        add_vec(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
        add_vec(32'h41200000, 32'h3F000000, 1'b0, 32'h41280000, 4'b0000);
        add_vec(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000);
        add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        add_vec(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
        add_vec(32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'b0000);
        add_vec(32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
        add_vec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        add_vec(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        add_vec(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001);

        // Reset state.
        @(negedge clk);
        #3;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_c", c, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream, consumer always ready.
        ready_mode = 0;
        foreach (vq[i]) begin
            issue(vq[i], 1'b1, i, w);
            chk($sformatf("no_stall_%0d", i), 32'(w), 32'd0);
        end
        idle();
        drain("drain_stream", 100);

        // Same stream under random backpressure.
        ready_mode = 1;
        foreach (vq[i]) issue(vq[i], 1'b0, 100 + i, w);
        idle();
        drain("drain_backpressure", 400);
        ready_mode = 0;
        repeat (3) @(negedge clk);

        // Fill the pipeline with the consumer stalled, then reset mid-flight.
        ready_mode = 2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) issue(vq[11 + i], 1'b0, 200 + i, w);
        @(negedge clk);
        in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000; op = 1'b0;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        held = 1'b0;
        sb_q.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        in_valid   = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        rv.a = 32'h40400000; rv.b = 32'h3F800000; rv.op = 1'b0;
        rv.c = 32'h40800000; rv.fl = 4'b0000;
        issue(rv, 1'b1, 300, w);
        idle();
        drain("drain_after_reset", 20);
        repeat (4) @(negedge clk);

        // Half-width format.
        run16("half_add", 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        run16("half_ovf", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
        run16("half_sub", 16'h3C00, 16'h3C00, 1'b1, 16'h0000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
